// File: rtl/sd_init_seq.sv
// sd_init_seq: SD card power-up/identification sequencer and CMD17 read issuer.
// Drives the command-line controller (start/cmd/arg/precnt/clkdiv) and reacts
// to its busy/done/timeout/syntaxe/resparg outputs.
// Optional build macro: SD_INIT_RETRY_EN -- when defined, ERROR waits
// RETRY_WAIT clk cycles and then restarts the flow from CMD0; when undefined,
// ERROR is terminal until rstn.
//
// Command handshake: an ISSUE state raises start for one cycle only while
// busy=0, registering cmd/arg/precnt, which then stay unchanged; the matching
// WAIT state ignores all inputs until the done pulse and evaluates
// timeout/syntaxe/resparg in that same cycle.
module sd_init_seq #(
   parameter logic [15:0] SLOWDIV        = 16'd50,
   parameter logic [15:0] FASTDIV        = 16'd1,
   parameter logic [15:0] PRECNT_INIT    = 16'd1000,
   parameter logic [15:0] PRECNT         = 16'd16,
   parameter logic [15:0] MAX_INIT_TRIES = 16'd4000
`ifdef SD_INIT_RETRY_EN
   ,
   parameter logic [23:0] RETRY_WAIT     = 24'd1000000
`endif
) (
   input  logic        clk,
   input  logic        rstn,
   output logic [15:0] clkdiv,
   output logic        start,
   output logic [15:0] precnt,
   output logic [5:0]  cmd,
   output logic [31:0] arg,
   input  logic        busy,
   input  logic        done,
   input  logic        timeout,
   input  logic        syntaxe,
   input  logic [31:0] resparg,
   output logic        init_done,
   output logic        init_err,
   output logic [1:0]  card_type,
   input  logic        rd_req,
   input  logic [31:0] rd_sector,
   output logic        ready,
   output logic        rd_go,
   input  logic        rd_data_done,
   output logic        rd_fail,
   output logic [4:0]  dbg_state
);

   // Each ISSUE state is even and its WAIT state is the next code.
   localparam logic [4:0] S_CMD0_I  = 5'd0;
   localparam logic [4:0] S_CMD0_W  = 5'd1;
   localparam logic [4:0] S_CMD8_I  = 5'd2;
   localparam logic [4:0] S_CMD8_W  = 5'd3;
   localparam logic [4:0] S_CMD55_I = 5'd4;
   localparam logic [4:0] S_CMD55_W = 5'd5;
   localparam logic [4:0] S_A41_I   = 5'd6;
   localparam logic [4:0] S_A41_W   = 5'd7;
   localparam logic [4:0] S_CMD2_I  = 5'd8;
   localparam logic [4:0] S_CMD2_W  = 5'd9;
   localparam logic [4:0] S_CMD3_I  = 5'd10;
   localparam logic [4:0] S_CMD3_W  = 5'd11;
   localparam logic [4:0] S_CMD7_I  = 5'd12;
   localparam logic [4:0] S_CMD7_W  = 5'd13;
   localparam logic [4:0] S_CMD16_I = 5'd14;
   localparam logic [4:0] S_CMD16_W = 5'd15;
   localparam logic [4:0] S_CMD17_I = 5'd16;
   localparam logic [4:0] S_CMD17_W = 5'd17;
   localparam logic [4:0] S_READY   = 5'd18;
   localparam logic [4:0] S_RDWAIT  = 5'd19;
   localparam logic [4:0] S_ERROR   = 5'd20;

   logic [4:0]  state;
   logic [15:0] rca;
   logic        sdv2;
   logic [15:0] try_cnt;
   logic [31:0] sector;
   logic        is_issue;
   logic [5:0]  iss_cmd;
   logic [31:0] iss_arg;
   logic [15:0] iss_pre;
   logic        rsp_err;
   logic        try_last;
   logic        unused_bits;

`ifdef SD_INIT_RETRY_EN
   logic [23:0] wait_cnt;
`endif

   assign rsp_err     = timeout | syntaxe;
   assign try_last    = (try_cnt + 16'd1) == MAX_INIT_TRIES;
   assign ready       = (state == S_READY);
   assign init_err    = (state == S_ERROR);
   assign dbg_state   = state;
   assign unused_bits = ^resparg[15:12];

   // Command index, argument and idle count for the current ISSUE state.
   always_comb begin
      is_issue = 1'b1;
      iss_cmd  = 6'd0;
      iss_arg  = 32'h0;
      iss_pre  = PRECNT;
      case (state)
         S_CMD0_I:  begin iss_cmd = 6'd0;  iss_pre = PRECNT_INIT; end
         S_CMD8_I:  begin iss_cmd = 6'd8;  iss_arg = 32'h0000_01AA; end
         S_CMD55_I: begin iss_cmd = 6'd55; iss_arg = {rca, 16'h0}; end
         S_A41_I:   begin
            iss_cmd = 6'd41;
            iss_arg = sdv2 ? 32'h40FF_8000 : 32'h00FF_8000;
         end
         S_CMD2_I:  iss_cmd = 6'd2;
         S_CMD3_I:  iss_cmd = 6'd3;
         S_CMD7_I:  begin iss_cmd = 6'd7;  iss_arg = {rca, 16'h0}; end
         S_CMD16_I: begin iss_cmd = 6'd16; iss_arg = 32'h0000_0200; end
         S_CMD17_I: begin
            iss_cmd = 6'd17;
            iss_arg = (card_type == 2'd3) ? sector : {sector[22:0], 9'd0};
         end
         default:   is_issue = 1'b0;
      endcase
   end

   // Sequencer state, command registers and card identity.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= S_CMD0_I;
         clkdiv    <= SLOWDIV;
         start     <= 1'b0;
         precnt    <= 16'h0;
         cmd       <= 6'h0;
         arg       <= 32'h0;
         init_done <= 1'b0;
         card_type <= 2'd0;
         rd_go     <= 1'b0;
         rd_fail   <= 1'b0;
         rca       <= 16'h0;
         sdv2      <= 1'b0;
         try_cnt   <= 16'h0;
         sector    <= 32'h0;
`ifdef SD_INIT_RETRY_EN
         wait_cnt  <= 24'h0;
`endif
      end else begin
         start   <= 1'b0;
         rd_go   <= 1'b0;
         rd_fail <= 1'b0;
         if (is_issue) begin
            if (!busy) begin
               start  <= 1'b1;
               cmd    <= iss_cmd;
               arg    <= iss_arg;
               precnt <= iss_pre;
               state  <= state + 5'd1;
            end
         end else begin
            case (state)
               S_CMD0_W: if (done) state <= S_CMD8_I;
               S_CMD8_W: if (done) begin
                  if (timeout) begin
                     sdv2  <= 1'b0;
                     state <= S_CMD55_I;
                  end else if (!syntaxe && resparg[11:0] == 12'h1AA) begin
                     sdv2  <= 1'b1;
                     state <= S_CMD55_I;
                  end else begin
                     state <= S_ERROR;
                  end
               end
               S_CMD55_W: if (done) begin
                  if (rsp_err) begin
                     try_cnt <= try_cnt + 16'd1;
                     state   <= try_last ? S_ERROR : S_CMD55_I;
                  end else begin
                     state <= S_A41_I;
                  end
               end
               S_A41_W: if (done) begin
                  try_cnt <= try_cnt + 16'd1;
                  if (!rsp_err && resparg[31]) begin
                     card_type <= sdv2 ? (resparg[30] ? 2'd3 : 2'd2) : 2'd1;
                     state     <= S_CMD2_I;
                  end else begin
                     state <= try_last ? S_ERROR : S_CMD55_I;
                  end
               end
               // R2 is long; a syntaxe flag on it is not meaningful.
               S_CMD2_W: if (done) state <= timeout ? S_ERROR : S_CMD3_I;
               S_CMD3_W: if (done) begin
                  if (rsp_err) state <= S_ERROR;
                  else begin
                     rca   <= resparg[31:16];
                     state <= S_CMD7_I;
                  end
               end
               S_CMD7_W: if (done) begin
                  if (rsp_err) state <= S_ERROR;
                  else begin
                     clkdiv <= FASTDIV;
                     if (card_type != 2'd3) state <= S_CMD16_I;
                     else begin
                        init_done <= 1'b1;
                        state     <= S_READY;
                     end
                  end
               end
               S_CMD16_W: if (done) begin
                  if (rsp_err) state <= S_ERROR;
                  else begin
                     init_done <= 1'b1;
                     state     <= S_READY;
                  end
               end
               S_READY: if (rd_req) begin
                  sector <= rd_sector;
                  state  <= S_CMD17_I;
               end
               S_CMD17_W: if (done) begin
                  if (rsp_err) begin
                     rd_fail <= 1'b1;
                     state   <= S_READY;
                  end else begin
                     rd_go <= 1'b1;
                     state <= S_RDWAIT;
                  end
               end
               // A read request arriving here, even with rd_data_done, is dropped.
               S_RDWAIT: if (rd_data_done) state <= S_READY;
               S_ERROR: begin
                  init_done <= 1'b0;
`ifdef SD_INIT_RETRY_EN
                  if (wait_cnt == RETRY_WAIT - 24'd1) begin
                     wait_cnt  <= 24'h0;
                     clkdiv    <= SLOWDIV;
                     card_type <= 2'd0;
                     rca       <= 16'h0;
                     sdv2      <= 1'b0;
                     try_cnt   <= 16'h0;
                     state     <= S_CMD0_I;
                  end else begin
                     wait_cnt <= wait_cnt + 24'd1;
                  end
`endif
               end
               default: state <= S_ERROR;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sd_init_seq.sv
// tb_sd_init_seq: directed bench for sd_init_seq with a command-controller
// responder. Expected commands are queued when a scenario is set up and
// compared as the DUT issues them; unexpected starts are flagged.
module tb_sd_init_seq;

   logic        clk;
   logic        rstn;
   logic [15:0] clkdiv;
   logic        start;
   logic [15:0] precnt;
   logic [5:0]  cmd;
   logic [31:0] arg;
   logic        busy;
   logic        done;
   logic        timeout;
   logic        syntaxe;
   logic [31:0] resparg;
   logic        init_done;
   logic        init_err;
   logic [1:0]  card_type;
   logic        rd_req;
   logic [31:0] rd_sector;
   logic        ready;
   logic        rd_go;
   logic        rd_data_done;
   logic        rd_fail;
   logic [4:0]  dbg_state;

   // {cmd, arg, precnt, clkdiv} expected at each start
   logic [69:0] exp_q[$];
   // {timeout, syntaxe, resparg} returned for each start
   logic [33:0] rsp_q[$];

   int pass_cnt  = 0;
   int total_cnt = 0;
   int go_cnt    = 0;
   int fail_cnt  = 0;
   int g0;
   int f0;

   sd_init_seq #(.MAX_INIT_TRIES(16'd3)) dut (
      .clk(clk), .rstn(rstn), .clkdiv(clkdiv), .start(start), .precnt(precnt),
      .cmd(cmd), .arg(arg), .busy(busy), .done(done), .timeout(timeout),
      .syntaxe(syntaxe), .resparg(resparg), .init_done(init_done),
      .init_err(init_err), .card_type(card_type), .rd_req(rd_req),
      .rd_sector(rd_sector), .ready(ready), .rd_go(rd_go),
      .rd_data_done(rd_data_done), .rd_fail(rd_fail), .dbg_state(dbg_state)
   );

   // clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic push(input logic [5:0] c, input logic [31:0] a, input logic [15:0] p,
                       input logic [15:0] d, input logic to, input logic se,
                       input logic [31:0] ra);
      exp_q.push_back({c, a, p, d});
      rsp_q.push_back({to, se, ra});
   endtask

   task automatic reset_checks(input string ph);
      chk({ph, "_start"},     start,     0);
      chk({ph, "_cmd"},       cmd,       0);
      chk({ph, "_arg"},       arg,       0);
      chk({ph, "_precnt"},    precnt,    0);
      chk({ph, "_clkdiv"},    clkdiv,    50);
      chk({ph, "_init_done"}, init_done, 0);
      chk({ph, "_init_err"},  init_err,  0);
      chk({ph, "_card_type"}, card_type, 0);
      chk({ph, "_ready"},     ready,     0);
      chk({ph, "_rd_go"},     rd_go,     0);
      chk({ph, "_rd_fail"},   rd_fail,   0);
   endtask

   // Assert reset, check outputs, then flush both queues; rstn stays low.
   task automatic reset_low(input string ph);
      rstn = 1'b0;
      #1;
      reset_checks(ph);
      repeat (3) @(negedge clk);
      exp_q.delete();
      rsp_q.delete();
   endtask

   task automatic pulse_rd(input logic [31:0] sec, input logic with_done);
      rd_sector    = sec;
      rd_req       = 1'b1;
      rd_data_done = with_done;
      @(negedge clk);
      rd_req       = 1'b0;
      rd_data_done = 1'b0;
      rd_sector    = 32'h0;
   endtask

   task automatic wait_init(input string ph);
      for (int i = 0; i < 3000 && !init_done; i++) @(negedge clk);
      chk({ph, "_init_done"}, init_done, 1);
   endtask

   // pulse counters
   initial begin
      forever begin
         @(negedge clk);
         if (rd_go)   go_cnt++;
         if (rd_fail) fail_cnt++;
      end
   end

   // command controller responder: compares each start against the scoreboard
   initial begin
      logic [33:0] r;
      busy = 1'b0; done = 1'b0; timeout = 1'b0; syntaxe = 1'b0; resparg = 32'h0;
      forever begin
         @(negedge clk);
         done = 1'b0; timeout = 1'b0; syntaxe = 1'b0;
         if (rstn && start) begin
            chk("start_while_busy", busy, 0);
            chk("start_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) chk("cmd_arg_precnt_clkdiv", {cmd, arg, precnt, clkdiv}, exp_q.pop_front());
            r = (rsp_q.size() != 0) ? rsp_q.pop_front() : {1'b1, 1'b0, 32'h0};
            busy = 1'b1;
            for (int i = 0; i < 4 && rstn; i++) @(negedge clk);
            busy = 1'b0;
            if (rstn) begin
               done = 1'b1; timeout = r[33]; syntaxe = r[32]; resparg = r[31:0];
            end
         end
      end
   end

   // directed sequence
   initial begin
      rstn = 1'b0; rd_req = 1'b0; rd_sector = 32'h0; rd_data_done = 1'b0;
      repeat (3) @(negedge clk);
      reset_checks("por");

      // SDHC card: two busy ACMD41 replies, then ready with CCS
      push(6'd0, 32'h0, 16'd1000, 16'd50, 1, 0, 32'h0);
      push(6'd8, 32'h1AA, 16'd16, 16'd50, 0, 0, 32'h1AA);
      for (int k = 0; k < 3; k++) begin
         push(6'd55, 32'h0, 16'd16, 16'd50, 0, 0, 32'h120);
         push(6'd41, 32'h40FF8000, 16'd16, 16'd50, 0, 0, (k == 2) ? 32'hC0FF8000 : 32'h00FF8000);
      end
      push(6'd2, 32'h0, 16'd16, 16'd50, 0, 1, 32'h0);
      push(6'd3, 32'h0, 16'd16, 16'd50, 0, 0, 32'h12340000);
      push(6'd7, 32'h12340000, 16'd16, 16'd50, 0, 0, 32'h0);
      @(negedge clk);
      rstn = 1'b1;
      wait_init("sdhc");
      chk("sdhc_card_type", card_type, 3);
      chk("sdhc_clkdiv_fast", clkdiv, 1);
      chk("sdhc_ready", ready, 1);
      chk("sdhc_init_err", init_err, 0);
      repeat (20) @(negedge clk);
      chk("sdhc_cmds_consumed", exp_q.size(), 0);

      // SDHC read of sector 5: block addressing
      push(6'd17, 32'h5, 16'd16, 16'd1, 0, 0, 32'h900);
      g0 = go_cnt; f0 = fail_cnt;
      pulse_rd(32'd5, 1'b0);
      chk("rd_ready_low", ready, 0);
      for (int i = 0; i < 100 && go_cnt == g0; i++) @(negedge clk);
      chk("rd_go_once", go_cnt - g0, 1);
      // request during the data stage must be ignored
      pulse_rd(32'd9, 1'b0);
      repeat (20) @(negedge clk);
      chk("rdwait_ready_low", ready, 0);
      chk("rdwait_no_extra_go", go_cnt - g0, 1);
      // data done with a simultaneous request: the request is dropped
      pulse_rd(32'd7, 1'b1);
      chk("data_done_ready", ready, 1);
      repeat (20) @(negedge clk);
      chk("dropped_req_ready", ready, 1);
      chk("rd_no_fail", fail_cnt - f0, 0);

      // CMD17 timeout: one rd_fail, no rd_go, back to ready
      push(6'd17, 32'h5, 16'd16, 16'd1, 1, 0, 32'h0);
      g0 = go_cnt; f0 = fail_cnt;
      pulse_rd(32'd5, 1'b0);
      for (int i = 0; i < 100 && fail_cnt == f0; i++) @(negedge clk);
      chk("rd_fail_pulse", fail_cnt - f0, 1);
      repeat (5) @(negedge clk);
      chk("rd_fail_single", fail_cnt - f0, 1);
      chk("rd_fail_no_go", go_cnt - g0, 0);
      chk("rd_fail_ready", ready, 1);

      // SDv1 card: CMD8 times out, CMD16 follows CMD7 at fast clock
      reset_low("rst_v1");
      push(6'd0, 32'h0, 16'd1000, 16'd50, 1, 0, 32'h0);
      push(6'd8, 32'h1AA, 16'd16, 16'd50, 1, 0, 32'h0);
      push(6'd55, 32'h0, 16'd16, 16'd50, 0, 0, 32'h0);
      push(6'd41, 32'h00FF8000, 16'd16, 16'd50, 0, 0, 32'h80FF8000);
      push(6'd2, 32'h0, 16'd16, 16'd50, 0, 0, 32'h0);
      push(6'd3, 32'h0, 16'd16, 16'd50, 0, 0, 32'hAAAA0000);
      push(6'd7, 32'hAAAA0000, 16'd16, 16'd50, 0, 0, 32'h0);
      push(6'd16, 32'h200, 16'd16, 16'd1, 0, 0, 32'h0);
      rstn = 1'b1;
      wait_init("v1");
      chk("v1_card_type", card_type, 1);
      chk("v1_cmds_consumed", exp_q.size(), 0);
      push(6'd17, 32'hA00, 16'd16, 16'd1, 0, 0, 32'h900);
      g0 = go_cnt;
      pulse_rd(32'd5, 1'b0);
      for (int i = 0; i < 100 && go_cnt == g0; i++) @(negedge clk);
      chk("v1_rd_go", go_cnt - g0, 1);
      pulse_rd(32'd0, 1'b1);
      chk("v1_ready_after_data", ready, 1);

      // reset in the middle of an ACMD41
      reset_low("rst_mid");
      push(6'd0, 32'h0, 16'd1000, 16'd50, 1, 0, 32'h0);
      push(6'd8, 32'h1AA, 16'd16, 16'd50, 0, 0, 32'h1AA);
      push(6'd55, 32'h0, 16'd16, 16'd50, 0, 0, 32'h0);
      push(6'd41, 32'h40FF8000, 16'd16, 16'd50, 0, 0, 32'h0);
      rstn = 1'b1;
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge clk);
      chk("mid_acmd41_reached", exp_q.size(), 0);
      repeat (2) @(negedge clk);
      reset_low("rst_acmd41");

      // ACMD41 never ready: error after the third try, then silence
      push(6'd0, 32'h0, 16'd1000, 16'd50, 1, 0, 32'h0);
      push(6'd8, 32'h1AA, 16'd16, 16'd50, 1, 0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         push(6'd55, 32'h0, 16'd16, 16'd50, 0, 0, 32'h0);
         push(6'd41, 32'h00FF8000, 16'd16, 16'd50, 0, 0, 32'h00FF8000);
      end
      rstn = 1'b1;
      for (int i = 0; i < 3000 && !init_err; i++) @(negedge clk);
      chk("tries_init_err", init_err, 1);
      chk("tries_cmds_consumed", exp_q.size(), 0);
      repeat (10000) @(negedge clk);
      chk("err_hold_init_err", init_err, 1);
      chk("err_hold_init_done", init_done, 0);
      chk("err_hold_ready", ready, 0);
      chk("err_card_type", card_type, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/sd_init_seq.md
Name: sd_init_seq

Overview:
Command sequencer that sits directly upstream of the SD command-line controller (sdcmd_ctrl). It drives that controller's start/cmd/arg/precnt/clkdiv inputs and consumes its busy/done/timeout/syntaxe/resparg outputs. It runs the SD card power-up and initialisation flow, identifies the card type and RCA, and switches the SD clock to fast rate. Once the card is ready, it issues CMD17 single-block reads on request and hands off to the data-line stage.

Parameters:
SLOWDIV, 16'd50, clkdiv value used during identification (sdclk at most 400 kHz)
FASTDIV, 16'd1, clkdiv value used after CMD7 succeeds
PRECNT_INIT, 16'd1000, idle sdclk count before CMD0 (at least 74 required)
PRECNT, 16'd16, idle sdclk count before every other command
MAX_INIT_TRIES, 16'd4000, maximum number of CMD55+ACMD41 iterations
RETRY_WAIT, 24'd1000000, clk cycles spent in ERROR before restart (optional feature only)

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
clkdiv  output  16  sdclk divider to the command controller
start  output  1  one-cycle command request
precnt  output  16  idle clocks before the command
cmd  output  6  command index
arg  output  32  command argument
busy  input  1  command controller busy
done  input  1  command finished (one-cycle pulse)
timeout  input  1  no response (valid with done)
syntaxe  input  1  response malformed (valid with done)
resparg  input  32  response argument
init_done  output  1  level; card ready for reads
init_err  output  1  level; initialisation failed
card_type  output  2  0 unknown, 1 SDv1, 2 SDv2 standard capacity, 3 SDHC/SDXC
rd_req  input  1  read request pulse (honoured only while ready)
rd_sector  input  32  sector address, sampled with rd_req
ready  output  1  idle in READY and able to accept rd_req
rd_go  output  1  one-cycle pulse; CMD17 accepted, data stage may start
rd_data_done  input  1  pulse from the data stage; block finished
rd_fail  output  1  one-cycle pulse; CMD17 timed out or had a syntax error

Behaviour:
- Reset (asynchronous, active-low) clears every output to 0, except clkdiv, which resets to SLOWDIV.
- Reset clears the state to CMD0 issue, rca=0, sdv2=0, try counter=0.
- Reset mid-operation abandons the command in flight.
- Command handshake:
  - Each command uses an ISSUE state and a WAIT state.
  - ISSUE asserts start for exactly one cycle, and only when busy=0.
  - cmd/arg/precnt are registered in ISSUE and held unchanged until done.
  - WAIT ignores everything until the done pulse, then evaluates timeout/syntaxe/resparg in that same cycle.
  - start is never asserted while busy=1, and never twice for one command.
- State flow (every command uses PRECNT unless stated otherwise):
  - CMD0: arg 0, precnt PRECNT_INIT. Any done goes to CMD8; a timeout is expected.
  - CMD8: arg 0x000001AA.
    - timeout: sdv2=0, go to CMD55.
    - ok and resparg[11:0]==0x1AA: sdv2=1, go to CMD55.
    - anything else: go to ERROR.
  - CMD55: arg {rca,16'h0}. A timeout or syntaxe counts as a failed try (see try rules below).
  - ACMD41 (cmd 41): arg is 0x40FF8000 if sdv2, else 0x00FF8000.
    - ok with resparg[31]=1: card_type = sdv2 ? (resparg[30] ? 3 : 2) : 1, go to CMD2.
    - otherwise: counts as a failed try.
  - Try rules for the CMD55/ACMD41 loop:
    - The try counter increments once per completed ACMD41, and once per failed CMD55.
    - When the counter reaches MAX_INIT_TRIES: go to ERROR. Otherwise go back to CMD55.
  - CMD2: arg 0. Timeout goes to ERROR; syntaxe is ignored (long R2 response).
  - CMD3: arg 0. Timeout or syntaxe goes to ERROR; otherwise rca=resparg[31:16].
  - CMD7: arg {rca,16'h0}.
    - ok: clkdiv becomes FASTDIV on the cycle after done.
    - error: go to ERROR.
    - Next state is CMD16 if card_type != 3, else READY.
  - CMD16: arg 0x00000200. Error goes to ERROR; ok goes to READY.
  - READY: init_done=1, ready=1.
    - On rd_req: latch rd_sector, ready=0, go to CMD17.
  - CMD17: arg = (card_type==3) ? sector : sector<<9 (upper bits dropped).
    - ok: pulse rd_go, go to RDWAIT.
    - error: pulse rd_fail, return to READY.
  - RDWAIT: rd_data_done returns to READY.
  - ERROR: init_err=1, init_done=0, start never asserted. Terminal unless the optional feature is compiled in.
- rd_req outside READY is ignored; no queueing.
- rd_req and rd_data_done in the same cycle: rd_data_done is processed first, and that rd_req is dropped.
- card_type is held from ACMD41 success until reset or restart.

Optional Feature:
SD_INIT_RETRY_EN:
- Defined: ERROR counts RETRY_WAIT clk cycles, then restarts. Restart resets clkdiv=SLOWDIV, card_type=0, rca=0, try counter=0, clears init_err, and returns to CMD0.
- Undefined: ERROR holds until rstn, and the wait counter is not built.

Test Plan:
- SDHC model: CMD8 echoes 0x1AA, ACMD41 returns 0x00FF8000 twice then 0xC0FF8000 -> commands issued are 0,8,55,41,55,41,55,41,2,3,7, with no CMD16. card_type=3, init_done=1, clkdiv goes from 50 to 1 after CMD7 done.
- SDv1 model: CMD8 times out -> ACMD41 arg 0x00FF8000, CMD16 arg 0x00000200 issued, card_type=1, init_done=1.
- MAX_INIT_TRIES=3 with ACMD41 always returning bit31=0 -> init_err=1 after the 3rd ACMD41, and no further start pulse for 10000 cycles (macro undefined).
- Reads after init: SDv1, rd_req sector 5 -> CMD17 arg 0x00000A00. SDHC, sector 5 -> arg 0x00000005. done ok -> one rd_go pulse; rd_data_done -> ready=1.
- CMD17 timeout -> single rd_fail pulse, no rd_go, ready=1 the following cycles. A rd_req during RDWAIT is ignored.
- rstn low during the ACMD41 loop -> all outputs 0, clkdiv=SLOWDIV. After release, the first start has cmd=0 and precnt=PRECNT_INIT; start never coincides with busy=1.
